imem_responder: RTL and testbench

Instruction-memory responder at the far end of the fetch interface: accepts 64-bit fetch addresses from the program counter / fetch stage and returns the 32-bit instruction word. Provides a fixed-latency synchronous memory pipeline and a small response FIFO for decode-side backpressure. Supports flush on redirect, so in-flight fetches from a discarded path are dropped. Also provides a write port for program preload by the testbench or loader.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/imem_responder_rsp_fifo.sv | 71 +++++++
 rtl/imem_responder.sv | 107 ++++++++++
 tb/tb_imem_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and constants for the fetch path.
package cpu_pkg;
  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] INST_ERR = 32'h0;

  // One fetch response as it travels through the memory pipeline and FIFO.
  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [INST_W-1:0] inst;
    logic              err;
  } rsp_t;
endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// Synchronous response FIFO; flush empties it and discards any same-cycle push or pop.
module rsp_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = 1'b0;
    do_pop   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      do_pop  = pop_i && !empty_o;
      do_push = push_i && (!full_o || do_pop);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency read pipeline feeding a credit-managed
// response FIFO, with redirect flush and a preload write port.
module imem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [XLEN-1:0]                req_addr,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [INST_W-1:0]              rsp_inst,
  output logic [XLEN-1:0]                rsp_addr,
  output logic                           rsp_err,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_addr,
  input  logic [INST_W-1:0]              wr_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int OW = $clog2(FIFO_DEPTH+LATENCY+1);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(DEPTH_WORDS) << 2;

  logic [INST_W-1:0]  mem_q [DEPTH_WORDS];
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  rsp_t               pipe_dat_q [LATENCY];

  logic [AW-1:0] req_idx;
  logic          req_err;
  logic          accept;
  rsp_t          req_rsp;
  rsp_t          fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic          fifo_pop;
  logic [OW-1:0] occ;

  assign req_idx = req_addr[2 +: AW];
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);

  always_comb begin
    req_rsp.addr = req_addr;
    req_rsp.err  = req_err;
    req_rsp.inst = req_err ? INST_ERR : mem_q[req_idx];
  end

  // Credits count everything already committed to land in the FIFO; a same-cycle
  // pop is deliberately ignored so ready never depends on rsp_ready.
  always_comb begin
    occ = OW'(fifo_count);
    for (int i = 0; i < LATENCY; i++) occ = occ + OW'(pipe_vld_q[i]);
  end

  assign req_ready = reset && !flush && !fifo_full && (occ < OW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    pipe_vld_d = '0;
    if (!flush) begin
      pipe_vld_d[0] = accept;
      for (int i = 1; i < LATENCY; i++) pipe_vld_d[i] = pipe_vld_q[i-1];
    end
  end

  // Stage boundary: valid tags are control state and take the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe_vld_q <= '0;
    else        pipe_vld_q <= pipe_vld_d;
  end

  // Stage boundary: array and payload carry no reset; a write racing a read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en)  mem_q[wr_addr] <= wr_data;
    if (accept) pipe_dat_q[0]  <= req_rsp;
    for (int i = 1; i < LATENCY; i++) pipe_dat_q[i] <= pipe_dat_q[i-1];
  end

  assign fifo_pop = rsp_valid && rsp_ready;

  rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (pipe_vld_q[LATENCY-1]),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .din_i   (pipe_dat_q[LATENCY-1]),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Outputs read zero whenever nothing is buffered, which also covers reset.
  assign rsp_valid = !fifo_empty;
  assign rsp_inst  = fifo_empty ? '0 : fifo_head.inst;
  assign rsp_addr  = fifo_empty ? '0 : fifo_head.addr;
  assign rsp_err   = fifo_empty ? 1'b0 : fifo_head.err;
endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench for imem_responder with default parameters.
module tb_imem_responder;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [63:0] rsp_addr;
  logic        rsp_err;
  logic        flush;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;

  imem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [63:0] a, output logic [31:0] inst,
                           output logic [63:0] ra, output logic err, output bit ok);
    bit acc;
    acc  = 1'b0;
    ok   = 1'b0;
    inst = '0;
    ra   = '0;
    err  = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 10 && !acc; i++) begin
      #1;
      if (req_ready) acc = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (rsp_valid) begin
        inst = rsp_inst;
        ra   = rsp_addr;
        err  = rsp_err;
        ok   = 1'b1;
      end
      tick();
    end
    if (!acc) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_inst !== 32'h0) begin errors++; $display("FAIL reset_rsp_inst: got %h expected 0", rsp_inst); end
    checks++; if (rsp_addr !== 64'h0) begin errors++; $display("FAIL reset_rsp_addr: got %h expected 0", rsp_addr); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 32'h1000 + 32'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    bit ready_low = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 8);
      req_addr  = 64'(c * 4);
      #1;
      if (c < 8 && !req_ready) ready_low = 1'b1;
      checks++;
      if (rsp_valid !== ((c >= 3) && (c < 11))) begin
        errors++; $display("FAIL b2b_rsp_valid iter %0d: got %b expected %b", c, rsp_valid, (c >= 3) && (c < 11));
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_inst !== 32'h1000 + 32'(n) || rsp_addr !== 64'(n * 4) || rsp_err !== 1'b0) begin
          errors++; $display("FAIL b2b_data #%0d: got inst %h addr %h err %b expected inst %h addr %h err 0",
                             n, rsp_inst, rsp_addr, rsp_err, 32'h1000 + 32'(n), 64'(n * 4));
        end
        n++;
      end
      tick();
    end
    req_valid = 1'b0;
    checks++; if (ready_low !== 1'b0) begin errors++; $display("FAIL b2b_req_ready: got low expected always high"); end
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", n); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int n = 0;
    bit hs;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_addr = 64'h20 + 64'(acc * 4);
      #1;
      hs = req_ready;
      tick();
      if (hs) acc++;
    end
    req_valid = 1'b0;
    #1;
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", req_ready); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle_pop: got %b expected 0", req_ready); end
    for (int i = 0; i < 8; i++) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (rsp_inst !== 32'h1008 + 32'(n) || rsp_addr !== 64'h20 + 64'(n * 4)) begin
          errors++; $display("FAIL bp_drain #%0d: got inst %h addr %h expected inst %h addr %h",
                             n, rsp_inst, rsp_addr, 32'h1008 + 32'(n), 64'h20 + 64'(n * 4));
        end
        n++;
      end
      tick();
      if (i == 0) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", n); end
  endtask

  task automatic test_flush();
    int stale = 0;
    logic [31:0] inst; logic [63:0] ra; logic err; bit ok;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1;
      req_addr  = 64'(c * 4);
      tick();
    end
    flush = 1'b1; req_valid = 1'b1; req_addr = 64'h40;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_req: got %b expected 0", req_ready); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_occ_zero: got req_ready %b expected 1", req_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL flush_stale: got %0d responses expected 0", stale); end
    fetch_one(64'h40, inst, ra, err, ok);
    checks++;
    if (!ok || inst !== 32'h1010 || ra !== 64'h40 || err !== 1'b0) begin
      errors++; $display("FAIL flush_after_fetch: got ok %b inst %h addr %h err %b expected inst 00001010 addr 40 err 0", ok, inst, ra, err);
    end
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL flush_extra_rsp: got %0d expected 0", stale); end
  endtask

  task automatic test_errors();
    logic [31:0] inst; logic [63:0] ra; logic err; bit ok;
    fetch_one(64'h6, inst, ra, err, ok);
    checks++;
    if (!ok || err !== 1'b1 || inst !== 32'h0 || ra !== 64'h6) begin
      errors++; $display("FAIL err_misaligned: got ok %b err %b inst %h addr %h expected err 1 inst 0 addr 6", ok, err, inst, ra);
    end
    fetch_one(64'h1000, inst, ra, err, ok);
    checks++;
    if (!ok || err !== 1'b1 || inst !== 32'h0 || ra !== 64'h1000) begin
      errors++; $display("FAIL err_range: got ok %b err %b inst %h addr %h expected err 1 inst 0 addr 1000", ok, err, inst, ra);
    end
    fetch_one(64'hFFC, inst, ra, err, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++; $display("FAIL err_last_word: got ok %b err %b expected err 0", ok, err);
    end
    fetch_one(64'h8, inst, ra, err, ok);
    checks++;
    if (!ok || err !== 1'b0 || inst !== 32'h1002 || ra !== 64'h8) begin
      errors++; $display("FAIL err_recover: got ok %b err %b inst %h addr %h expected err 0 inst 00001002 addr 8", ok, err, inst, ra);
    end
  endtask

  task automatic test_collision();
    logic [31:0] inst; logic [63:0] ra; logic err; bit ok;
    wr_en = 1'b1; wr_addr = 10'd5; wr_data = 32'hAAAA;
    tick();
    wr_data = 32'hBBBB; req_valid = 1'b1; req_addr = 64'h14; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL coll_ready: got %b expected 1", req_ready); end
    tick();
    wr_en = 1'b0; req_valid = 1'b0;
    ok = 1'b0; inst = '0;
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if (rsp_valid) begin inst = rsp_inst; ok = 1'b1; end
      tick();
    end
    checks++;
    if (!ok || inst !== 32'hAAAA) begin errors++; $display("FAIL coll_old_word: got ok %b inst %h expected 0000aaaa", ok, inst); end
    fetch_one(64'h14, inst, ra, err, ok);
    checks++;
    if (!ok || inst !== 32'hBBBB) begin errors++; $display("FAIL coll_new_word: got ok %b inst %h expected 0000bbbb", ok, inst); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    logic [31:0] inst; logic [63:0] ra; logic err; bit ok;
    rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req_valid = 1'b1;
      req_addr  = 64'(c * 4);
      tick();
    end
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_req_ready: got %b expected 0", req_ready); end
    @(posedge clk);
    @(posedge clk);
    #4;
    reset = 1'b1;
    rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) stale++;
      tick();
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale: got %0d responses expected 0", stale); end
    fetch_one(64'h20, inst, ra, err, ok);
    checks++;
    if (!ok || inst !== 32'h1008 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_mem_kept: got ok %b inst %h err %b expected inst 00001008 err 0", ok, inst, err);
    end
    fetch_one(64'h14, inst, ra, err, ok);
    checks++;
    if (!ok || inst !== 32'hBBBB) begin errors++; $display("FAIL rstmid_mem_word5: got ok %b inst %h expected 0000bbbb", ok, inst); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_errors();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
